// File: rtl/lv1_lv2_pkg.sv
// lv1_lv2_pkg: shared arbiter FSM states and requester index encoding (index = 2*core + ofs)
package lv1_lv2_pkg;
    typedef enum logic [1:0] {IDLE, GRANT, TURN} arb_state_t;
    localparam int REQ_DL_OFS = 0;
    localparam int REQ_IL_OFS = 1;
endpackage

// File: rtl/rr_pick_lv1_lv2.sv
// rr_pick_lv1_lv2: combinational round-robin picker, first set request at or after ptr with wrap
module rr_pick_lv1_lv2 #(
    parameter int NUM_REQ = 8,
    parameter int REQ_WID = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [REQ_WID-1:0] ptr,
    output logic               found,
    output logic [REQ_WID-1:0] idx
);
    // scan from the farthest offset back towards ptr so the closest request is the last to win
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[REQ_WID'((int'(ptr) + i) % NUM_REQ)]) begin
                found = 1'b1;
                idx   = REQ_WID'((int'(ptr) + i) % NUM_REQ);
            end
        end
    end
endmodule

// File: rtl/bus_arb_lv1_lv2.sv
// bus_arb_lv1_lv2: round-robin L1/L2 bus arbiter with registered one-hot grant and one dead turn cycle
// Optional grant hold timeout is compiled in with BUS_ARB_LV1_LV2_TIMEOUT_EN.
module bus_arb_lv1_lv2
    import lv1_lv2_pkg::*;
#(
    parameter int NUM_REQ     = 8,
    parameter int REQ_WID     = 3,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] bus_lv1_lv2_req_proc,
    output logic [NUM_REQ-1:0] bus_lv1_lv2_gnt_proc,
    output logic [REQ_WID-1:0] gnt_id,
    output logic               bus_busy,
    output logic               arb_timeout
);
    arb_state_t         state_q, state_d;
    logic [REQ_WID-1:0] rr_q, rr_d, id_d, rr_next, pick_idx;
    logic [NUM_REQ-1:0] gnt_d;
    logic               busy_d, pick_found, hold, expire;

    if (REQ_WID != $clog2(NUM_REQ) || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("bus_arb_lv1_lv2: REQ_WID must equal clog2(NUM_REQ) and TIMEOUT_CYC must be positive");
    end

    rr_pick_lv1_lv2 #(.NUM_REQ(NUM_REQ), .REQ_WID(REQ_WID)) u_pick (
        .req   (bus_lv1_lv2_req_proc),
        .ptr   (rr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign hold    = bus_lv1_lv2_req_proc[gnt_id];
    assign rr_next = (int'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + 1'b1;

`ifdef BUS_ARB_LV1_LV2_TIMEOUT_EN
    localparam int CNT_WID = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_WID-1:0] cnt_q, cnt_d;
    logic               to_q, to_d;

    assign expire      = cnt_q == CNT_WID'(TIMEOUT_CYC);
    assign arb_timeout = to_q;

    // count visible grant cycles; the count is 1 during the first grant cycle
    always_comb begin
        cnt_d = (state_q != GRANT) ? CNT_WID'(1) : (hold && !expire) ? cnt_q + 1'b1 : '0;
        to_d  = (state_q == GRANT) && hold && expire;
    end

    // hold counter and timeout pulse registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end
`else
    assign expire      = 1'b0;
    assign arb_timeout = 1'b0;
`endif

    // next state: GRANT holds until release/expiry; TURN lasts one cycle and its exit edge is the IDLE arbitration
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        gnt_d   = bus_lv1_lv2_gnt_proc;
        id_d    = gnt_id;
        busy_d  = bus_busy;
        if (state_q == GRANT) begin
            if (!hold || expire) begin
                state_d = TURN;
                rr_d    = rr_next;
                gnt_d   = '0;
                id_d    = '0;
                busy_d  = 1'b0;
            end
        end else if (pick_found) begin
            state_d = GRANT;
            gnt_d   = NUM_REQ'(1) << pick_idx;
            id_d    = pick_idx;
            busy_d  = 1'b1;
        end else begin
            state_d = IDLE;
            gnt_d   = '0;
            id_d    = '0;
            busy_d  = 1'b0;
        end
    end

    // state, pointer and registered grant outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q              <= IDLE;
            rr_q                 <= '0;
            bus_lv1_lv2_gnt_proc <= '0;
            gnt_id               <= '0;
            bus_busy             <= 1'b0;
        end else begin
            state_q              <= state_d;
            rr_q                 <= rr_d;
            bus_lv1_lv2_gnt_proc <= gnt_d;
            gnt_id               <= id_d;
            bus_busy             <= busy_d;
        end
    end
endmodule

// File: tb/tb_bus_arb_lv1_lv2.sv
// tb_bus_arb_lv1_lv2: directed self-checking bench for the round-robin L1/L2 bus arbiter
module tb_bus_arb_lv1_lv2;
`ifdef BUS_ARB_LV1_LV2_TIMEOUT_EN
    localparam int TO_CYC = 4;
`else
    localparam int TO_CYC = 255;
`endif
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = '0;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       bus_busy, arb_timeout;
    int         n_checks = 0;
    int         n_fails = 0;

    always #5 clk = ~clk;

    bus_arb_lv1_lv2 #(.NUM_REQ(8), .REQ_WID(3), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .bus_lv1_lv2_req_proc (req),
        .bus_lv1_lv2_gnt_proc (gnt),
        .gnt_id               (gnt_id),
        .bus_busy             (bus_busy),
        .arb_timeout          (arb_timeout)
    );

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        assert (obs === want) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic chk_gnt(input string tag, input logic [7:0] g, input logic [2:0] id);
        chk({tag, "/gnt"}, {24'd0, gnt}, {24'd0, g});
        chk({tag, "/id"}, {29'd0, gnt_id}, {29'd0, id});
        chk({tag, "/busy"}, {31'd0, bus_busy}, {31'd0, |g});
        chk({tag, "/tmo"}, {31'd0, arb_timeout}, 32'd0);
    endtask

    initial begin
        int to_seen;
        step(2);
        chk_gnt("reset", 8'h00, 3'd0);
`ifdef BUS_ARB_LV1_LV2_TIMEOUT_EN
        rst_n = 1'b1;
        req = 8'h12;
        step;
        chk_gnt("to_grant1", 8'h02, 3'd1);
        repeat (3) begin
            step;
            chk_gnt("to_hold1", 8'h02, 3'd1);
        end
        step;
        chk("to_revoke/gnt", {24'd0, gnt}, 32'd0);
        chk("to_revoke/busy", {31'd0, bus_busy}, 32'd0);
        chk("to_revoke/pulse", {31'd0, arb_timeout}, 32'd1);
        step;
        chk_gnt("to_grant4", 8'h10, 3'd4);
`else
        rst_n = 1'b1;
        req = 8'h04;
        step;
        chk_gnt("first_grant2", 8'h04, 3'd2);
        step(3);
        chk_gnt("hold2", 8'h04, 3'd2);
        req[5] = 1'b1;
        repeat (5) begin
            step;
            chk_gnt("no_preempt", 8'h04, 3'd2);
        end
        req[2] = 1'b0;
        step;
        chk_gnt("turn_after2", 8'h00, 3'd0);
        step;
        chk_gnt("grant5", 8'h20, 3'd5);
        req = 8'h00;
        step;
        chk_gnt("turn_after5", 8'h00, 3'd0);
        step;
        chk_gnt("idle_empty", 8'h00, 3'd0);
        req = 8'h40;
        step;
        chk_gnt("grant6", 8'h40, 3'd6);
        req = 8'h81;
        step;
        chk_gnt("turn_after6", 8'h00, 3'd0);
        step;
        chk_gnt("ptr7_wins", 8'h80, 3'd7);
        req = 8'h01;
        step;
        chk_gnt("turn_after7", 8'h00, 3'd0);
        req = 8'h81;
        step;
        chk_gnt("wrap_ptr0_wins", 8'h01, 3'd0);
        req = 8'h80;
        step;
        chk_gnt("turn_after0", 8'h00, 3'd0);
        step;
        chk_gnt("grant7_again", 8'h80, 3'd7);
        req = 8'h00;
        step(2);
        req = 8'h02;
        step;
        chk_gnt("grant1", 8'h02, 3'd1);
        req = 8'h00;
        step(2);
        req = 8'h08;
        step;
        chk_gnt("grant3", 8'h08, 3'd3);
        rst_n = 1'b0;
        req = 8'h0A;
        step;
        chk_gnt("reset_revoke", 8'h00, 3'd0);
        step;
        chk_gnt("reset_hold", 8'h00, 3'd0);
        rst_n = 1'b1;
        step;
        chk_gnt("post_reset_ptr0", 8'h02, 3'd1);
        req = 8'h08;
        step;
        chk_gnt("post_reset_turn", 8'h00, 3'd0);
        step;
        chk_gnt("regrant3", 8'h08, 3'd3);
        rst_n = 1'b0;
        req = 8'h00;
        step;
        rst_n = 1'b1;
        req = 8'hFF;
        step;
        for (int k = 0; k < 8; k++) begin
            chk_gnt("rr_grant", 8'(1 << k), 3'(k));
            step;
            chk_gnt("rr_hold", 8'(1 << k), 3'(k));
            req[k] = 1'b0;
            step;
            chk_gnt("rr_turn", 8'h00, 3'd0);
            req[k] = 1'b1;
            step;
        end
        chk_gnt("rr_wrap0", 8'h01, 3'd0);
        rst_n = 1'b0;
        req = 8'h00;
        step;
        rst_n = 1'b1;
        req = 8'h02;
        step;
        to_seen = 0;
        repeat (300) begin
            step;
            to_seen += int'(arb_timeout);
        end
        chk_gnt("hold_forever", 8'h02, 3'd1);
        chk("no_timeout_pulse", to_seen, 32'd0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
